// File: rtl/fb_writer_if.sv
// Pixel-stream in / frame-memory write-port out bundle for fb_writer.
// slave = the writer block, master = the pixel source / memory side.
interface fb_writer_if;
  logic        pix_valid;
  logic        pix_sof;
  logic [23:0] pix_data;
  logic        pix_ready;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;
  logic        frame_done;
  logic        sof_err;

  modport slave (
    input  pix_valid, pix_sof, pix_data,
    output pix_ready, wr_en, wr_addr, wr_data, frame_done, sof_err
  );

  modport master (
    output pix_valid, pix_sof, pix_data,
    input  pix_ready, wr_en, wr_addr, wr_data, frame_done, sof_err
  );
endinterface

// File: rtl/fb_writer.sv
// Raster pixel stream to frame-memory writes; write port registered (1-cycle latency).
// Ready is high except for the single DONE cycle after each completed frame.
module fb_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        clk,
  input  logic        rst,
  fb_writer_if.slave  bus
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t        state_q, state_d;
  logic [XW-1:0] x_q, x_d, cur_x;
  logic [YW-1:0] y_q, y_d, cur_y;
  logic [18:0]   addr_q, addr_d, cur_addr;

  logic          ready, xfer, write, restart, last;

  logic          wr_en_q;
  logic [18:0]   wr_addr_q;
  logic [23:0]   wr_data_q;
  logic          frame_done_q;
  logic          sof_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (write) state_d = last ? DONE : WRITE;
      WRITE:   if (write && last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write either continues the raster or, on a restart/new frame, starts from (0,0).
  always_comb begin
    ready   = (state_q != DONE);
    xfer    = bus.pix_valid & ready;
    write   = 1'b0;
    restart = 1'b0;
    case (state_q)
      IDLE:  write = xfer & bus.pix_sof;
      WRITE: begin
        write   = xfer;
        restart = xfer & bus.pix_sof & ((x_q != '0) || (y_q != '0));
      end
      default: ;
    endcase
    cur_x    = (state_q == IDLE || restart) ? '0 : x_q;
    cur_y    = (state_q == IDLE || restart) ? '0 : y_q;
    cur_addr = (state_q == IDLE || restart) ? '0 : addr_q;
    last     = (cur_x == XW'(H_RES - 1)) && (cur_y == YW'(V_RES - 1));
  end

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    addr_d = addr_q;
    if (state_q == DONE) begin
      x_d    = '0;
      y_d    = '0;
      addr_d = '0;
    end else if (write) begin
      if (last) begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
      end else begin
        addr_d = cur_addr + 19'd1;
        if (cur_x == XW'(H_RES - 1)) begin
          x_d = '0;
          y_d = cur_y + YW'(1);
        end else begin
          x_d = cur_x + XW'(1);
          y_d = cur_y;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      addr_q       <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      addr_q       <= addr_d;
      wr_en_q      <= write;
      wr_addr_q    <= write ? cur_addr : wr_addr_q;
      wr_data_q    <= write ? bus.pix_data : wr_data_q;
      frame_done_q <= write & last;
      sof_err_q    <= restart;
    end
  end

  assign bus.pix_ready  = ready;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sof_err    = sof_err_q;

endmodule

// File: tb/tb_fb_writer.sv
// Scoreboard bench for fb_writer on a reduced 8x4 raster.
module tb_fb_writer;
  localparam int H = 8;
  localparam int V = 4;
  localparam int N = H * V;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   writes = 0;

  typedef struct {
    logic [18:0] addr;
    logic [23:0] data;
    logic        fd;
    logic        se;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  fb_writer_if bus();

  fb_writer #(.H_RES(H), .V_RES(V)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every write must match the head expectation, in the cycle after acceptance.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        writes++;
        if (exp_q.size() == 0) begin
          check("unexpected_write_addr", {13'd0, bus.wr_addr}, 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("wr_addr", {13'd0, bus.wr_addr}, {13'd0, e.addr});
          check("wr_data", {8'd0, bus.wr_data}, {8'd0, e.data});
          check("frame_done", {31'd0, bus.frame_done}, {31'd0, e.fd});
          check("sof_err", {31'd0, bus.sof_err}, {31'd0, e.se});
          check("write_latency", cyc, e.cyc);
        end
      end else begin
        check("frame_done_idle", {31'd0, bus.frame_done}, 32'd0);
        check("sof_err_idle", {31'd0, bus.sof_err}, 32'd0);
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
          exp_t e;
          e = exp_q.pop_front();
          check("missing_write_addr", 32'hFFFF_FFFF, {13'd0, e.addr});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic sof, input logic [23:0] d, input logic ew,
                      input logic [18:0] ea, input logic efd, input logic ese);
    logic rdy;
    bit   done = 0;
    bus.pix_valid = 1'b1;
    bus.pix_sof   = sof;
    bus.pix_data  = d;
    for (int i = 0; i < 8 && !done; i++) begin
      rdy = bus.pix_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1;
        if (ew) exp_q.push_back('{addr: ea, data: d, fd: efd, se: ese, cyc: cyc});
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
  endtask

  task automatic ready_after_frame();
    check("ready_low_in_done", {31'd0, bus.pix_ready}, 32'd0);
    idle(1);
    check("ready_back_high", {31'd0, bus.pix_ready}, 32'd1);
  endtask

  task automatic frame(input logic [23:0] base, input bit gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps) idle($urandom_range(0, 1));
      send(i == 0, base + 24'(i), 1'b1, 19'(i), i == N - 1, 1'b0);
    end
    ready_after_frame();
  endtask

  initial begin
    int w0;
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = '0;

    // Reset state
    #1;
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_wr_addr", {13'd0, bus.wr_addr}, 32'd0);
    check("rst_wr_data", {8'd0, bus.wr_data}, 32'd0);
    check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
    check("rst_sof_err", {31'd0, bus.sof_err}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("ready_after_reset", {31'd0, bus.pix_ready}, 32'd1);

    // Non-sof pixels in IDLE are dropped, then a full frame (covers line wraps 7->8 etc.)
    for (int i = 0; i < 5; i++) send(1'b0, 24'hC0_0000 + 24'(i), 1'b0, '0, 1'b0, 1'b0);
    frame(24'h00_0000, 1'b0);

    // Full frame with random gaps: contiguous writes, exactly N of them
    w0 = writes;
    frame(24'h5A_0000, 1'b1);
    check("gap_write_count", writes - w0, N);

    // Unexpected sof mid-frame restarts at address 0
    for (int i = 0; i < 10; i++) send(i == 0, 24'h11_0000 + 24'(i), 1'b1, 19'(i), 1'b0, 1'b0);
    send(1'b1, 24'hBE_EF00, 1'b1, 19'd0, 1'b0, 1'b1);
    for (int i = 1; i < N; i++) send(1'b0, 24'h22_0000 + 24'(i), 1'b1, 19'(i), i == N - 1, 1'b0);
    ready_after_frame();

    // Asynchronous reset mid-frame
    for (int i = 0; i < 5; i++) send(i == 0, 24'h33_0100 + 24'(i), 1'b1, 19'(i), 1'b0, 1'b0);
    check("pre_rst_wr_en", {31'd0, bus.wr_en}, 32'd1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("async_rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("async_rst_wr_addr", {13'd0, bus.wr_addr}, 32'd0);
    check("async_rst_wr_data", {8'd0, bus.wr_data}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    check("ready_after_midframe_rst", {31'd0, bus.pix_ready}, 32'd1);
    for (int i = 0; i < 3; i++) send(1'b0, 24'h44_0000 + 24'(i), 1'b0, '0, 1'b0, 1'b0);
    frame(24'h66_0000, 1'b0);

    idle(3);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
